// File: rtl/alu_op_sequencer_pkg.sv
// Shared types, op-code boundaries and op classification for the ALU op sequencer.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MC_WAIT,
        RESP
    } alu_seq_state_t;

    typedef enum logic [1:0] {
        SINGLE,
        MULTI,
        ILLEGAL
    } alu_op_class_t;

    localparam logic [OP_W-1:0] OP_SINGLE_LAST = 5'd15;
    localparam logic [OP_W-1:0] OP_MC_FIRST    = 5'd16;
    localparam logic [OP_W-1:0] OP_MC_LAST     = 5'd19;

    // Map a select code to its execution class.
    function automatic alu_op_class_t op_class(input logic [OP_W-1:0] op);
        if (op <= OP_SINGLE_LAST) begin
            return SINGLE;
        end else if ((op >= OP_MC_FIRST) && (op <= OP_MC_LAST)) begin
            return MULTI;
        end else begin
            return ILLEGAL;
        end
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the issue stage and the sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned N = 8
);
    import alu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [N-1:0]        req_a;
    logic [N-1:0]        req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [N-1:0]        rsp_data;
    logic                rsp_err;

    // Issue side: sends requests, consumes responses.
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Issue controller for the ALU result mux: one op in flight, single- or
// multi-cycle execution with a done timeout, response with error flag.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned MC_TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_op_sequencer_if.slave  bus,
    output logic [OP_W-1:0]    alu_sel,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    input  logic [N-1:0]       alu_result,
    output logic               mc_start,
    input  logic               mc_done,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(MC_TIMEOUT);

    alu_seq_state_t     r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_alu_sel;
    logic [N-1:0]       r_alu_a;
    logic [N-1:0]       r_alu_b;
    logic               r_mc_start;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [N-1:0]       r_rsp_data;
    logic               r_rsp_err;
    logic               r_busy;
    alu_op_class_t      w_class;

    assign w_class = op_class(bus.req_op);

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_sel   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_mc_start  <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        // Illegal ops leave the datapath registers untouched.
                        if (w_class != ILLEGAL) begin
                            r_alu_sel <= bus.req_op;
                            r_alu_a   <= bus.req_a;
                            r_alu_b   <= bus.req_b;
                        end
                        case (w_class)
                            SINGLE: begin
                                r_state <= EXEC;
                            end
                            MULTI: begin
                                r_state    <= MC_WAIT;
                                r_mc_start <= 1'b1;
                                r_cnt      <= '0;
                            end
                            default: begin
                                r_state     <= RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= '0;
                                r_rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                MC_WAIT: begin
                    r_mc_start <= 1'b0;
                    // Done is checked first so it wins a tie with expiry.
                    if (mc_done) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(MC_TIMEOUT - 1)) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign alu_sel       = r_alu_sel;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign mc_start      = r_mc_start;
    assign busy          = r_busy;
    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;

endmodule
